// File: rtl/gpio_bus_master.sv
`timescale 1ns/1ps
// gpio_bus_master
//   Sole bus initiator for the GPIO register block. Periodically reads the
//   button-event latch (register 0) and applies the captured events to an
//   8-bit counter. When any event was seen, it clears the latch and then
//   refreshes the red LEDs (register 1) and both seven-segment digits
//   (registers 2 and 3). After reset the display is refreshed once, so it
//   shows 00.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   rd_data  in   GPIO read data, valid the cycle after the rd_en cycle
//   addr     out  register address (0 buttons, 1 leds, 2 hex0, 3 hex1)
//   rd_en    out  one-cycle read strobe
//   wr_en    out  one-cycle write strobe
//   wr_data  out  write data
//   count    out  current counter value
//   paused   out  pause flag
//   busy     out  high whenever the sequencer is not idle
module gpio_bus_master #(
  parameter int unsigned POLL_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rd_data,
  output logic [1:0]  addr,
  output logic        rd_en,
  output logic        wr_en,
  output logic [31:0] wr_data,
  output logic [7:0]  count,
  output logic        paused,
  output logic        busy
);

  // Timer only has to reach POLL_CYCLES-1.
  localparam int unsigned TW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_EVAL,
    ST_WR_CLR, ST_WR_LED, ST_WR_HEX0, ST_WR_HEX1
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      ev_q, ev_d;
  logic [7:0]      count_q, count_d;
  logic            paused_q, paused_d;

  // Only the event bits of the latch carry meaning.
  logic unused_rd_bits;
  assign unused_rd_bits = ^rd_data[31:4];

  // Active-low segment codes, decimal point (bit7) always off.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      timer_q  <= '0;
      ev_q     <= '0;
      count_q  <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ev_q     <= ev_d;
      count_q  <= count_d;
      paused_q <= paused_d;
    end
  end

  // Next-state and event application.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ev_d     = ev_q;
    count_d  = count_q;
    paused_d = paused_q;
    case (state_q)
      ST_INIT:    state_d = ST_WR_LED;
      ST_IDLE: begin
        // Timer only moves here; it is left at zero on exit, so it reads
        // zero everywhere outside IDLE.
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = ST_RD_REQ;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        ev_d    = rd_data[3:0];
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (ev_q == 4'h0) begin
          state_d = ST_IDLE;
        end else begin
          // Clear wins over inc/dec; inc+dec together cancel; pause
          // blocks inc/dec but not clear. Pause toggle is separate.
          if (ev_q[2])                      count_d = 8'h00;
          else if (ev_q[0] && ev_q[1])      count_d = count_q;
          else if (ev_q[0] && !paused_q)    count_d = count_q + 8'd1;
          else if (ev_q[1] && !paused_q)    count_d = count_q - 8'd1;
          if (ev_q[3]) paused_d = !paused_q;
          state_d = ST_WR_CLR;
        end
      end
      ST_WR_CLR:  state_d = ST_WR_LED;
      ST_WR_LED:  state_d = ST_WR_HEX0;
      ST_WR_HEX0: state_d = ST_WR_HEX1;
      ST_WR_HEX1: state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  // Moore bus decode from registered state and data only, so an
  // asynchronous reset drops any strobe in the same cycle.
  always_comb begin
    addr    = 2'd0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 32'h0;
    case (state_q)
      ST_RD_REQ: begin
        addr  = 2'd0;
        rd_en = 1'b1;
      end
      ST_WR_CLR: begin
        addr  = 2'd0;
        wr_en = 1'b1;
      end
      ST_WR_LED: begin
        addr    = 2'd1;
        wr_en   = 1'b1;
        wr_data = {14'b0, paused_q, 9'b0, count_q};
      end
      ST_WR_HEX0: begin
        addr    = 2'd2;
        wr_en   = 1'b1;
        wr_data = {24'b0, seg7(count_q[3:0])};
      end
      ST_WR_HEX1: begin
        addr    = 2'd3;
        wr_en   = 1'b1;
        wr_data = {24'b0, seg7(count_q[7:4])};
      end
      default: ;
    endcase
  end

  assign count  = count_q;
  assign paused = paused_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_bus_master.sv
`timescale 1ns/1ps
module tb_gpio_bus_master;

  localparam int POLL = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rd_data = 32'h0;
  logic [1:0]  addr;
  logic        rd_en, wr_en;
  logic [31:0] wr_data;
  logic [7:0]  count;
  logic        paused, busy;

  gpio_bus_master #(.POLL_CYCLES(POLL)) dut (
    .clk(clk), .reset_n(reset_n), .rd_data(rd_data),
    .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data),
    .count(count), .paused(paused), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state and scoreboard of expected bus writes {addr,data}.
  logic [7:0] m_count = 8'h00;
  logic       m_paused = 1'b0;
  logic [33:0] sb_q[$];
  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic push_display();
    sb_q.push_back({2'd1, (32'(m_paused) << 17) | 32'(m_count)});
    sb_q.push_back({2'd2, 32'(seg_tab[m_count[3:0]])});
    sb_q.push_back({2'd3, 32'(seg_tab[m_count[7:4]])});
  endtask

  task automatic model_apply(input logic [3:0] ev);
    if (ev != 4'h0) begin
      if (ev[2])                 m_count = 8'h00;
      else if (ev[0] && ev[1])   m_count = m_count;
      else if (ev[0] && !m_paused) m_count = m_count + 8'd1;
      else if (ev[1] && !m_paused) m_count = m_count - 8'd1;
      if (ev[3]) m_paused = !m_paused;
      sb_q.push_back({2'd0, 32'h0});
      push_display();
    end
  endtask

  // Bus monitor: checks strobes and pops the scoreboard on every write.
  int idle_cnt = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_en || wr_en) chk("one_strobe", 32'(rd_en & wr_en), 32'h0);
      if (rd_en) begin
        chk("rd_addr", 32'(addr), 32'h0);
        chk("idle_gap", 32'(idle_cnt), 32'(POLL));
      end
      if (wr_en) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_write", 32'(addr), 32'hFFFF_FFFF);
        end else begin
          logic [33:0] e;
          e = sb_q.pop_front();
          chk("wr_addr", 32'(addr), 32'(e[33:32]));
          chk("wr_data", wr_data, e[31:0]);
          $display("write addr=%0d data=0x%0h (expected addr=%0d data=0x%0h)",
                   addr, wr_data, e[33:32], e[31:0]);
        end
      end
      idle_cnt <= busy ? 0 : idle_cnt + 1;
    end else begin
      idle_cnt <= 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  // Wait for the poll read, answer it with ev (junk in the ignored upper
  // bits), then scramble rd_data while it must be ignored.
  task automatic answer_poll(input logic [3:0] ev, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!rd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rd_en) begin
      chk("poll_timeout", 32'(rd_en), 32'h1);
    end else begin
      ok = 1'b1;
      rd_data = {$urandom_range(0, 32'h0FFF_FFFF), ev};
      model_apply(ev);
      @(negedge clk);
      @(negedge clk);
      rd_data = $urandom;
    end
  endtask

  task automatic poll(input logic [3:0] ev);
    bit ok;
    answer_poll(ev, ok);
    if (ok) wait_idle();
    chk("count", 32'(count), 32'(m_count));
    chk("paused", 32'(paused), 32'(m_paused));
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("poll ev=0x%0h count=0x%0h paused=%0d (model 0x%0h/%0d)",
             ev, count, paused, m_count, m_paused);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(addr), 32'h0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'h0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'h0);
    chk({tag, "_wr_data"}, wr_data, 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_paused"}, 32'(paused), 32'h0);
  endtask

  initial begin
    bit ok;
    int n;
    // Power-on reset.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    push_display();
    reset_n = 1'b1;
    wait_idle();
    chk("init_drained", 32'(sb_q.size()), 32'h0);

    // Three increments: 1, 2, 3.
    for (int i = 0; i < 3; i++) poll(4'h1);
    // No events: no writes.
    poll(4'h0);
    // Clear, then wrap down and up.
    poll(4'h4);
    poll(4'h2);
    poll(4'h1);
    poll(4'h2);
    // Walk up from 0xFF to 0x37.
    for (int i = 0; i < 8'h38; i++) poll(4'h1);
    poll(4'h5);
    poll(4'h1);
    poll(4'h3);
    // Pause handling.
    poll(4'h8);
    poll(4'h1);
    poll(4'h2);
    poll(4'h8);
    poll(4'h1);
    poll(4'h8);
    poll(4'h4);
    poll(4'h8);
    poll(4'h2);

    // Reset pulse landing in the LED write.
    answer_poll(4'h1, ok);
    n = 0;
    while (!(wr_en && addr == 2'd1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("led_reached", 32'(wr_en && addr == 2'd1), 32'h1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    chk("midreset_busy", 32'(busy), 32'h1);
    sb_q.delete();
    m_count = 8'h00;
    m_paused = 1'b0;
    @(negedge clk);
    @(negedge clk);
    push_display();
    reset_n = 1'b1;
    wait_idle();
    chk("reinit_drained", 32'(sb_q.size()), 32'h0);
    poll(4'h1);
    poll(4'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
